// File: rtl/lsensor_seq_mc.sv
// Multi-channel line-sensor readout sequencer: one timing engine drives NUM_CH sensors in
// lockstep, fetches integration/line/blank settings from config RAM and emits pixel strobes.
module lsensor_seq_mc #(
   parameter int unsigned PIX_NUM    = 512,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned RAM_LAT    = 1,
   parameter int unsigned SP_TIMEOUT = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_in,
   input  logic                       stop_in,
   input  logic                       cont_mode_in,
   output logic                       reset_o,
   output logic                       sensor_clk_o,
   input  logic [NUM_CH-1:0]          ad_sp,
   output logic                       pix_valid_o,
   output logic [$clog2(PIX_NUM)-1:0] pix_idx_o,
   output logic [15:0]                line_idx_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [1:0]                 err_o,
   output logic                       cfg_ram_rd_o,
   output logic [7:0]                 cfg_ram_addr_o,
   input  logic [31:0]                cfg_ram_din
);

   localparam int unsigned PixW = $clog2(PIX_NUM);

   typedef enum logic [2:0] {
      StIdle, StCfgRd, StInteg, StWaitSp, StData, StBlank, StDone
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;            // shared per-state cycle counter
   logic [31:0] integ_q, integ_d;
   logic [31:0] lines_q, lines_d;
   logic [31:0] blank_q, blank_d;
   logic [31:0] line_cnt_q, line_cnt_d;  // lines finished in this capture (not wrapping at 16 bits)
   logic [15:0] line_idx_q, line_idx_d;
   logic        cont_q, cont_d;
   logic [1:0]  err_q, err_d;
   logic        start_q;
   logic        start_edge;
   logic        skew;
   logic [31:0] din_nz;

   assign start_edge = start_in & ~start_q;
   // Any channel disagreeing with channel 0 counts as skew.
   assign skew       = (ad_sp != {NUM_CH{ad_sp[0]}});
   // A zero setting behaves as one.
   assign din_nz     = (cfg_ram_din == 32'd0) ? 32'd1 : cfg_ram_din;

   // Next-state and datapath updates; stop_in overrides everything outside idle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      integ_d    = integ_q;
      lines_d    = lines_q;
      blank_d    = blank_q;
      line_cnt_d = line_cnt_q;
      line_idx_d = line_idx_q;
      cont_d     = cont_q;
      err_d      = err_q;
      unique case (state_q)
         StIdle: begin
            if (start_edge && !stop_in) begin
               state_d    = StCfgRd;
               cnt_d      = '0;
               cont_d     = cont_mode_in;
               err_d      = '0;
               line_idx_d = '0;
               line_cnt_d = '0;
            end
         end
         StCfgRd: begin
            // Reads go out at cnt 0..2; each lands RAM_LAT cycles later.
            cnt_d = cnt_q + 32'd1;
            if (cnt_q == RAM_LAT) integ_d = din_nz;
            if (cnt_q == RAM_LAT + 1) lines_d = din_nz;
            if (cnt_q == RAM_LAT + 2) begin
               blank_d = din_nz;
               state_d = StInteg;
               cnt_d   = '0;
            end
         end
         StInteg: begin
            if (cnt_q == integ_q - 32'd1) begin
               state_d = StWaitSp;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StWaitSp: begin
            if (ad_sp[0]) begin
               if (skew) err_d[1] = 1'b1;
               state_d = StData;
               cnt_d   = '0;
            end else if (cnt_q == SP_TIMEOUT - 1) begin
               err_d[0] = 1'b1;
               state_d  = StDone;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StData: begin
            if (cnt_q == PIX_NUM - 1) begin
               state_d = StBlank;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StBlank: begin
            if (cnt_q == blank_q - 32'd1) begin
               cnt_d = '0;
               if (!cont_q && (line_cnt_q == lines_q - 32'd1)) begin
                  state_d = StDone;
               end else begin
                  line_idx_d = line_idx_q + 16'd1;
                  line_cnt_d = line_cnt_q + 32'd1;
                  state_d    = StInteg;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
      if (stop_in && (state_q != StIdle)) begin
         state_d = StIdle;
         cnt_d   = '0;
      end
   end

   // State and configuration registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         integ_q    <= '0;
         lines_q    <= '0;
         blank_q    <= '0;
         line_cnt_q <= '0;
         line_idx_q <= '0;
         cont_q     <= 1'b0;
         err_q      <= '0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         integ_q    <= integ_d;
         lines_q    <= lines_d;
         blank_q    <= blank_d;
         line_cnt_q <= line_cnt_d;
         line_idx_q <= line_idx_d;
         cont_q     <= cont_d;
         err_q      <= err_d;
         start_q    <= start_in;
      end
   end

   // Outputs decoded from registered state so reset clears them at once.
   always_comb begin
      reset_o        = (state_q == StInteg);
      pix_valid_o    = (state_q == StData);
      pix_idx_o      = (state_q == StData) ? cnt_q[PixW-1:0] : '0;
      line_idx_o     = line_idx_q;
      busy_o         = (state_q != StIdle);
      done_o         = (state_q == StDone);
      err_o          = err_q;
      cfg_ram_rd_o   = (state_q == StCfgRd) && (cnt_q < 32'd3);
      cfg_ram_addr_o = cfg_ram_rd_o ? (cnt_q[7:0] + 8'd1) : 8'd0;
   end

   assign sensor_clk_o = ~clk;

endmodule

// File: doc/lsensor_seq_mc.md
# lsensor_seq_mc

Parametrised line-sensor readout sequencer. It succeeds the single-sensor G11620 sequencer and drives NUM_CH sensors in lockstep from one timing engine. It fetches integration, line-count and blank settings from the config RAM with a configurable read latency, runs single-shot or continuous multi-line capture, and emits a per-pixel valid strobe with pixel and line indices. It adds start-pulse timeout and channel-skew error reporting. It sits between the config RAM / host control and the sensor front-end, alongside the ADC capture path.

## Interface
Parameters:
- PIX_NUM, 512: pixels per line (≥2).
- NUM_CH, 2: sensors driven in lockstep (≥1).
- RAM_LAT, 1: config RAM read latency in cycles (≥1).
- SP_TIMEOUT, 4096: max cycles waiting for ad_sp before error.

Ports:
- clk  in  1: single clock; all logic on its rising edge.
- rst  in  1: asynchronous, active-high reset.
- start_in  in  1: capture request; rising edge sampled in IDLE.
- stop_in  in  1: abort; level-sensitive, highest priority.
- cont_mode_in  in  1: 1 = continuous lines until stop_in; sampled at start.
- reset_o  out  1: sensor RESET (integration window), shared by all channels.
- sensor_clk_o  out  1: sensor clock = ~clk.
- ad_sp  in  NUM_CH: per-sensor AD start pulse.
- pix_valid_o  out  1: pixel data strobe.
- pix_idx_o  out  $clog2(PIX_NUM): pixel index while pix_valid_o.
- line_idx_o  out  16: current line number, wraps at 65535→0.
- busy_o  out  1: high in every state except IDLE.
- done_o  out  1: one-cycle completion pulse.
- err_o  out  2: sticky {skew, timeout}; cleared on accepted start.
- cfg_ram_rd_o  out  1: config read strobe.
- cfg_ram_addr_o  out  8: config read address.
- cfg_ram_din  in  32: config read data, valid RAM_LAT cycles after the strobe.

## Operation
- Reset values: all outputs 0 except sensor_clk_o (follows ~clk). The state machine resets to IDLE and all counters clear.
- States: IDLE, CFG_RD, INTEG, WAIT_SP, DATA, BLANK, DONE.
- IDLE: start_in high with its previous-cycle value low → CFG_RD. This latches cont_mode_in, clears err_o, and clears line_idx_o. start_in is ignored outside IDLE.
- CFG_RD: issues three one-cycle reads on consecutive cycles at addresses 0x01 (integ cycles N), 0x02 (line count L), 0x03 (blank cycles B). Each is captured RAM_LAT cycles after its strobe. After the last capture → INTEG.
- Zero rule: N, L or B equal to 0 is treated as 1. All three are 32-bit unsigned.
- INTEG: reset_o high for exactly N cycles → WAIT_SP.
- WAIT_SP: reset_o low; waits for ad_sp[0] high.
  - If any ad_sp[k] differs from ad_sp[0] in that cycle, set err_o[1] and proceed normally.
  - If SP_TIMEOUT cycles elapse with ad_sp[0] low, set err_o[0] → DONE.
- DATA: pix_valid_o high for exactly PIX_NUM cycles; pix_idx_o counts 0..PIX_NUM-1 → BLANK.
- BLANK: B cycles. At exit:
  - If the line just captured was line L-1 and cont_mode is 0 → DONE.
  - Otherwise, increment line_idx_o → INTEG.
  - In continuous mode, L is ignored beyond the first read.
- DONE: done_o high one cycle → IDLE.
- stop_in high in any non-IDLE state → IDLE on the next edge. pix_valid_o and reset_o go low, no done_o pulse, err_o is retained.
- stop_in and a start edge together in IDLE → stay IDLE.
- rst asserted in any state: outputs go to reset values immediately (asynchronously).

## Timing
- Start edge sampled at edge T → cfg_ram_rd_o high cycles T+1, T+2, T+3 with addr 0x01, 0x02, 0x03.
- Captures occur at T+1+RAM_LAT through T+3+RAM_LAT. reset_o first high at T+4+RAM_LAT.
- reset_o high N cycles. WAIT_SP begins the following cycle.
- ad_sp[0] sampled high at edge S → pix_valid_o high cycles S+1..S+PIX_NUM.
- BLANK occupies the next B cycles. The next line's reset_o rises in the cycle after BLANK ends.
- Timeout: err_o[0] rises and DONE is entered SP_TIMEOUT cycles after WAIT_SP entry. done_o follows one cycle later.
- line_idx_o updates on the BLANK→INTEG transition. It is stable throughout INTEG/WAIT_SP/DATA/BLANK of that line.
- busy_o rises the cycle after the start edge. It falls the cycle after done_o, or one cycle after stop_in is sampled.

## Test plan
Bench parameters: PIX_NUM=8, NUM_CH=2, RAM_LAT=2, SP_TIMEOUT=16.
- RAM {1:5, 2:2, 3:4}, start pulse, ad_sp=2'b11 two cycles after each WAIT_SP entry → reads at addrs 1,2,3; reset_o high 5 cycles twice; pix_valid_o 8 cycles twice with idx 0..7; line_idx_o 0 then 1; blank 4 cycles; single done_o; err_o=0.
- RAM {1:0, 2:0, 3:0} → reset_o high exactly 1 cycle, one line, blank 1 cycle, done_o once.
- cont_mode_in=1, L=1 → ≥3 lines with line_idx_o 0,1,2. stop_in raised in DATA at idx 3 → pix_valid_o and busy_o low the next cycle; no done_o.
- ad_sp held 0 → err_o=2'b01 exactly 16 cycles after WAIT_SP entry; done_o pulses; no pix_valid_o.
- ad_sp=2'b01 in the detection cycle → err_o=2'b10; line still captured with 8 pix_valid_o cycles. The next start clears err_o to 0.
- rst pulsed mid-DATA → all outputs 0 immediately; a second start during busy is ignored; a fresh start after reset runs a normal sequence.
